// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// The DMEM_MISALIGN_CHECK_EN build uses be_legal() to reject misaligned writes.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic MEM_READ   = 1'b1;
    localparam logic MEM_WRITE  = 1'b0;
    localparam int   WAIT_CNT_W = 4;

    // Legal lane patterns: single byte anywhere, halfword on even offset,
    // full word on offset 0, or no lanes at all.
    function automatic logic be_legal(input logic [3:0] be, input logic [1:0] a);
        logic ok;
        ok = 1'b0;
        if (be == 4'b0000)                         ok = 1'b1;
        if (be == (4'b0001 << a))                  ok = 1'b1;
        if (!a[0] && (be == (4'b0011 << a)))       ok = 1'b1;
        if ((a == 2'd0) && (be == 4'b1111))        ok = 1'b1;
        return ok;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Byte-lane-writable synchronous word array with a registered read port.
// Contents are not reset; only the read register clears on reset.
module dmem_ram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_we,
    input  logic          i_re,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_idx,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int i = 0; i < 4; i++) begin
                if (i_be[i]) r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
    end

    // Read register only moves on a read, so it holds across writes.
    always_ff @(posedge i_clk) begin
        if (i_rst)     r_rdata <= '0;
        else if (i_re) r_rdata <= r_mem[i_idx];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: capture request, count wait states, access, pulse ready.
// Optional DMEM_MISALIGN_CHECK_EN suppresses and flags illegal lane patterns on writes.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        mem_req,
    input  logic        mem_rw_mode,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_write_data,
    input  logic [3:0]  mem_byte_en,
    output logic [31:0] mem_read_data,
    output logic        mem_ready,
    output logic        mem_err,
    output state_t      o_state
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_CYCLES);

    state_t                r_state;
    state_t                w_next;
    logic [WAIT_CNT_W-1:0] r_wait_cnt;
    logic                  r_rw;
    logic [AW-1:0]         r_idx;
    logic [1:0]            r_lo;
    logic [31:0]           r_wdata;
    logic [3:0]            r_be;
    logic                  r_err;

    logic                  w_access;
    logic                  w_acc_rw;
    logic [AW-1:0]         w_acc_idx;
    logic [1:0]            w_acc_lo;
    logic [31:0]           w_acc_wdata;
    logic [3:0]            w_acc_be;
    logic                  w_illegal;
    logic                  w_we;
    logic                  w_re;
    logic                  w_unused;

    always_comb begin
        w_next   = r_state;
        w_access = 1'b0;
        case (r_state)
            IDLE: begin
                if (mem_req) begin
                    w_next   = (WAIT_CYCLES > 0) ? WAIT : RESP;
                    w_access = (WAIT_CYCLES == 0);
                end
            end
            WAIT: begin
                if (r_wait_cnt == WAIT_CNT_W'(1)) begin
                    w_next   = RESP;
                    w_access = 1'b1;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // With zero wait states the access happens on the capture edge itself,
    // so the live inputs stand in for the not-yet-loaded capture registers.
    always_comb begin
        if (r_state == IDLE) begin
            w_acc_rw    = mem_rw_mode;
            w_acc_idx   = mem_addr[AW+1:2];
            w_acc_lo    = mem_addr[1:0];
            w_acc_wdata = mem_write_data;
            w_acc_be    = mem_byte_en;
        end else begin
            w_acc_rw    = r_rw;
            w_acc_idx   = r_idx;
            w_acc_lo    = r_lo;
            w_acc_wdata = r_wdata;
            w_acc_be    = r_be;
        end
    end

`ifdef DMEM_MISALIGN_CHECK_EN
    assign w_illegal = (w_acc_rw == MEM_WRITE) && !be_legal(w_acc_be, w_acc_lo);
`else
    assign w_illegal = 1'b0;
`endif

    assign w_we = w_access && !i_rst && (w_acc_rw == MEM_WRITE) && !w_illegal;
    assign w_re = w_access && !i_rst && (w_acc_rw == MEM_READ);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= w_access && w_illegal;
            if (r_state == IDLE && mem_req) r_wait_cnt <= WAIT_INIT;
            else if (r_state == WAIT)       r_wait_cnt <= r_wait_cnt - WAIT_CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (r_state == IDLE && mem_req) begin
            r_rw    <= mem_rw_mode;
            r_idx   <= mem_addr[AW+1:2];
            r_lo    <= mem_addr[1:0];
            r_wdata <= mem_write_data;
            r_be    <= mem_byte_en;
        end
    end

    dmem_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_ram (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_we   (w_we),
        .i_re   (w_re),
        .i_be   (w_acc_be),
        .i_idx  (w_acc_idx),
        .i_wdata(w_acc_wdata),
        .o_rdata(mem_read_data)
    );

    assign mem_ready = (r_state == RESP);
    assign mem_err   = r_err;
    assign o_state   = r_state;
    assign w_unused  = ^{mem_addr[31:AW+2], r_lo};

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance with no wait states, one with three.
// Honours DMEM_MISALIGN_CHECK_EN when the bundle is built with it.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req3, rw;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic [31:0] rdata0, rdata3;
    logic        ready0, ready3, err0, err3;
    state_t      st0, st3;

    int          tests  = 0;
    int          failed = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mdl0[int];
    logic [31:0] mdl3[int];
    logic [31:0] last_rd0;

    int          lat;
    logic [31:0] rd;
    logic        er, ra;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .mem_req(req0), .mem_rw_mode(rw), .mem_addr(addr),
        .mem_write_data(wdata), .mem_byte_en(be), .mem_read_data(rdata0),
        .mem_ready(ready0), .mem_err(err0), .o_state(st0)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(3)) u_dut3 (
        .i_clk(clk), .i_rst(rst), .mem_req(req3), .mem_rw_mode(rw), .mem_addr(addr),
        .mem_write_data(wdata), .mem_byte_en(be), .mem_read_data(rdata3),
        .mem_ready(ready3), .mem_err(err3), .o_state(st3)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] b);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic logic exp_err(input logic [1:0] lo, input logic [3:0] b);
`ifdef DMEM_MISALIGN_CHECK_EN
        logic ok;
        ok = (b == 4'b0000);
        case (lo)
            2'd0: if (b == 4'b0001 || b == 4'b0011 || b == 4'b1111) ok = 1'b1;
            2'd1: if (b == 4'b0010) ok = 1'b1;
            2'd2: if (b == 4'b0100 || b == 4'b1100) ok = 1'b1;
            default: if (b == 4'b1000) ok = 1'b1;
        endcase
        return !ok;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'(a[11:2]);
    endfunction

    // Drive one request and wait for its response; lat = cycles from capture
    // to ready (-1 on timeout), ra = ready seen again on the following cycle.
    task automatic issue(input bit sel3, input logic rw_i, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] b, output int lat_o,
                         output logic [31:0] rd_o, output logic er_o, output logic ra_o);
        bit got;
        @(negedge clk);
        rw = rw_i; addr = a; wdata = d; be = b;
        if (sel3) req3 = 1'b1; else req0 = 1'b1;
        @(posedge clk); #1;
        req0 = 1'b0; req3 = 1'b0;
        addr = $urandom; wdata = $urandom; be = 4'($urandom_range(0, 15)); rw = ~rw_i;
        got = 1'b0; lat_o = -1; rd_o = 'x; er_o = 1'bx;
        for (int c = 1; c <= 40 && !got; c++) begin
            if (sel3 ? ready3 : ready0) begin
                got = 1'b1; lat_o = c;
                rd_o = sel3 ? rdata3 : rdata0;
                er_o = sel3 ? err3 : err0;
            end else begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        ra_o = sel3 ? ready3 : ready0;
    endtask

    task automatic sb_write(input bit sel3, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] b);
        if (!exp_err(a[1:0], b)) begin
            if (sel3) mdl3[idx_of(a)] = merge(mdl3.exists(idx_of(a)) ? mdl3[idx_of(a)] : 'x, d, b);
            else      mdl0[idx_of(a)] = merge(mdl0.exists(idx_of(a)) ? mdl0[idx_of(a)] : 'x, d, b);
        end
        issue(sel3, MEM_WRITE, a, d, b, lat, rd, er, ra);
    endtask

    task automatic sb_read(input bit sel3, input logic [31:0] a);
        exp_q.push_back(sel3 ? mdl3[idx_of(a)] : mdl0[idx_of(a)]);
        issue(sel3, MEM_READ, a, 32'h0, 4'h0, lat, rd, er, ra);
    endtask

    task automatic test_reset();
        rst = 1'b1; req0 = 1'b0; req3 = 1'b0; rw = MEM_READ;
        addr = '0; wdata = '0; be = '0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (ready0 !== 1'b0) begin failed++; $display("FAIL reset_ready0 got=%b exp=0", ready0); end
        tests++; if (rdata0 !== 32'h0) begin failed++; $display("FAIL reset_rdata0 got=%h exp=0", rdata0); end
        tests++; if (err0 !== 1'b0) begin failed++; $display("FAIL reset_err0 got=%b exp=0", err0); end
        tests++; if (st0 !== IDLE) begin failed++; $display("FAIL reset_state0 got=%0d exp=%0d", st0, IDLE); end
        tests++; if (ready3 !== 1'b0 || rdata3 !== 32'h0 || err3 !== 1'b0 || st3 !== IDLE) begin
            failed++; $display("FAIL reset_dut3 rdy=%b rd=%h err=%b st=%0d exp 0/0/0/IDLE", ready3, rdata3, err3, st3);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_write_read();
        sb_write(0, 32'h10, 32'hDEADBEEF, 4'b1111);
        tests++; if (lat !== 1) begin failed++; $display("FAIL wr_latency got=%0d exp=1", lat); end
        tests++; if (ra !== 1'b0) begin failed++; $display("FAIL wr_pulse_width got=%b exp=0", ra); end
        tests++; if (rd !== 32'h0) begin failed++; $display("FAIL wr_rdata_hold got=%h exp=0", rd); end
        sb_read(0, 32'h10);
        tests++; if (lat !== 1) begin failed++; $display("FAIL rd_latency got=%0d exp=1", lat); end
        tests++; if (rd !== exp_q.pop_front()) begin failed++; $display("FAIL rd_data got=%h exp=%h", rd, 32'hDEADBEEF); end
        tests++; if (er !== 1'b0) begin failed++; $display("FAIL rd_err got=%b exp=0", er); end
        last_rd0 = rd;
    endtask

    task automatic test_byte_write();
        sb_write(0, 32'h10, 32'h0000AB00, 4'b0010);
        tests++; if (lat !== 1 || er !== 1'b0) begin failed++; $display("FAIL byte_wr lat=%0d err=%b exp 1/0", lat, er); end
        sb_read(0, 32'h10);
        tests++; if (rd !== 32'hDEADABEF) begin failed++; $display("FAIL byte_rd got=%h exp=%h", rd, 32'hDEADABEF); end
        tests++; if (mdl0[4] !== 32'hDEADABEF) begin failed++; $display("FAIL byte_model got=%h exp=%h", mdl0[4], 32'hDEADABEF); end
        void'(exp_q.pop_front());
        last_rd0 = rd;
    endtask

    task automatic test_wait_alias();
        sb_write(1, 32'h10, 32'hCAFEF00D, 4'b1111);
        tests++; if (lat !== 4) begin failed++; $display("FAIL wait_wr_latency got=%0d exp=4", lat); end
        tests++; if (ra !== 1'b0) begin failed++; $display("FAIL wait_pulse_width got=%b exp=0", ra); end
        sb_read(1, 32'h10 + DEPTH * 4);
        tests++; if (lat !== 4) begin failed++; $display("FAIL wait_rd_latency got=%0d exp=4", lat); end
        tests++; if (rd !== exp_q.pop_front()) begin failed++; $display("FAIL alias_data got=%h exp=%h", rd, 32'hCAFEF00D); end
        sb_read(1, 32'h13);
        tests++; if (rd !== exp_q.pop_front()) begin failed++; $display("FAIL lowbits_data got=%h exp=%h", rd, 32'hCAFEF00D); end
    endtask

    task automatic test_reset_mid_wait();
        int rdy_seen;
        sb_write(1, 32'h20, 32'h11112222, 4'b1111);
        @(negedge clk);
        rw = MEM_WRITE; addr = 32'h20; wdata = 32'h12345678; be = 4'b1111; req3 = 1'b1;
        @(posedge clk); #1;
        req3 = 1'b0;
        @(posedge clk); #1;
        tests++; if (st3 !== WAIT) begin failed++; $display("FAIL midwait_state got=%0d exp=%0d", st3, WAIT); end
        rst = 1'b1;
        rdy_seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (ready3 !== 1'b0) rdy_seen++;
        end
        @(negedge clk); rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (ready3 !== 1'b0) rdy_seen++;
        end
        tests++; if (rdy_seen !== 0) begin failed++; $display("FAIL midwait_ready got=%0d pulses exp=0", rdy_seen); end
        tests++; if (st3 !== IDLE) begin failed++; $display("FAIL midwait_idle got=%0d exp=%0d", st3, IDLE); end
        sb_read(1, 32'h20);
        tests++; if (lat !== 4) begin failed++; $display("FAIL midwait_rd_latency got=%0d exp=4", lat); end
        tests++; if (rd !== exp_q.pop_front()) begin failed++; $display("FAIL midwait_data got=%h exp=%h", rd, 32'h11112222); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, d;
        logic [3:0]  b;
        logic [1:0]  lo;
        int          k;
        int          errs;
        errs = 0;
        for (int i = 0; i < 8; i++) sb_write(0, 32'h40 + 32'(4 * i), $urandom, 4'b1111);
        for (int n = 0; n < 30; n++) begin
            a = 32'h40 + 32'(4 * $urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) begin
                sb_read(0, a + 32'($urandom_range(0, 3)));
                if (lat !== 1 || ra !== 1'b0 || er !== 1'b0 || rd !== exp_q.pop_front()) begin
                    errs++; $display("FAIL b2b_read n=%0d lat=%0d rd=%h er=%b", n, lat, rd, er);
                end
                last_rd0 = rd;
            end else begin
                d = $urandom; k = $urandom_range(0, 3); lo = 2'($urandom_range(0, 3));
                case (k)
                    0: begin lo = 2'd0; b = 4'b1111; end
                    1: b = 4'b0001 << lo;
                    2: begin lo = {lo[1], 1'b0}; b = 4'b0011 << lo; end
                    default: b = 4'b0000;
                endcase
                sb_write(0, a + 32'(lo), d, b);
                if (lat !== 1 || ra !== 1'b0 || er !== 1'b0 || rd !== last_rd0) begin
                    errs++; $display("FAIL b2b_write n=%0d lat=%0d rd=%h exp_hold=%h er=%b", n, lat, rd, last_rd0, er);
                end
            end
        end
        tests++; if (errs !== 0) failed++;
    endtask

    task automatic test_misalign();
        sb_write(0, 32'h20, 32'hAABBCCDD, 4'b1111);
        sb_write(0, 32'h21, 32'h00001111, 4'b0011);
        tests++; if (er !== exp_err(2'd1, 4'b0011)) begin failed++; $display("FAIL misalign_err got=%b exp=%b", er, exp_err(2'd1, 4'b0011)); end
        tests++; if (lat !== 1) begin failed++; $display("FAIL misalign_latency got=%0d exp=1", lat); end
        tests++; if (ra !== 1'b0) begin failed++; $display("FAIL misalign_err_width got=%b exp=0", ra); end
        sb_read(0, 32'h20);
        tests++; if (rd !== exp_q.pop_front() || er !== 1'b0) begin failed++; $display("FAIL misalign_word got=%h er=%b exp=%h", rd, er, mdl0[8]); end
        sb_write(0, 32'h22, 32'h55660000, 4'b1100);
        tests++; if (er !== 1'b0) begin failed++; $display("FAIL aligned_half_err got=%b exp=0", er); end
        sb_read(0, 32'h20);
        tests++; if (rd !== exp_q.pop_front()) begin failed++; $display("FAIL aligned_half_word got=%h exp=%h", rd, mdl0[8]); end
        last_rd0 = rd;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        last_rd0 = 32'h0;
        test_reset();
        test_write_read();
        test_byte_write();
        test_wait_alias();
        test_reset_mid_wait();
        test_back_to_back();
        test_misalign();
        tests++; if (exp_q.size() !== 0) begin failed++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Single-port data-memory responder serving the load/store request interface driven by the integer execution unit: address, read/write mode, lane-positioned write data and byte enables. Captures a request, inserts a configurable number of wait states, performs the word access, and returns read data with a one-cycle ready pulse. Sits between the execution unit's memory port and the data RAM storage.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words. Power of two, at least 4.
- WAIT_CYCLES, 0: extra cycles between request capture and response. Range 0..15.
- i_clk  in  1  the one clock; all state updates on its rising edge.
- i_rst  in  1  reset, synchronous and active-high.
- mem_req  in  1  level request. It is integrated from the execution unit's stall_pc.
- mem_rw_mode  in  1  1 = read, 0 = write.
- mem_addr  in  32  byte address; word index = mem_addr[AW+1:2], where AW = $clog2(DEPTH_WORDS).
- mem_write_data  in  32  lane-positioned write data.
- mem_byte_en  in  4  write lane enables; bit i covers data[8i+7:8i]. Ignored for reads.
- mem_read_data  out  32  full word read.
- mem_ready  out  1  one-cycle response pulse.
- mem_err  out  1  misaligned-write flag; see Configuration.

## Operation
- FSM states are IDLE, WAIT and RESP.
- **IDLE:** if mem_req=1, capture addr, rw, data and byte_en, and load wait_cnt=WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, otherwise RESP.
- **WAIT:** decrement wait_cnt each cycle. Go to RESP on the edge where wait_cnt==1.
- **Access:** performed on the edge that enters RESP, using only the captured values.
  - Write: each enabled lane of mem[idx] is updated; other lanes are untouched.
  - Read: mem_read_data <= mem[idx].
- **RESP:**
  - mem_ready=1 for exactly this cycle.
  - mem_req is ignored. Next state is always IDLE.
- mem_req still high in IDLE counts as a new request. The requester drops mem_req in its mem_ready cycle.
- Input changes during WAIT or RESP have no effect.
- mem_read_data holds the last read value until the next read completes. Writes leave it unchanged.
- Address bits above AW+1 are ignored, so addresses alias modulo DEPTH_WORDS*4. mem_addr[1:0] does not affect the index.
- A write with byte_en=0000 completes normally and changes nothing.
- Memory contents are not reset and power up as X.

## Timing
- Reset values: state=IDLE, wait_cnt=0, mem_ready=0, mem_read_data=0, mem_err=0.
- Reset asserted in WAIT aborts the request and its access never happens. The memory array is unchanged.
- Reset asserted in RESP: mem_ready is 0 on the next cycle, and the access has already committed.
- Latency: request sampled at edge N; mem_ready and valid read data appear in cycle N+1+WAIT_CYCLES.
- Throughput: one request per 2+WAIT_CYCLES cycles.
- Read-after-write to the same word in consecutive requests returns the new data.

## Configuration
- DMEM_MISALIGN_CHECK_EN defined:
  - For writes, a captured byte_en must be legal for addr[1:0]. Legal patterns: 0001<<a, 0011<<a with a even, 1111 with a==0, or 0000.
  - An illegal write is suppressed and asserts mem_err together with mem_ready. mem_err is 0 in all other cycles.
  - Reads are never flagged.
- DMEM_MISALIGN_CHECK_EN undefined: mem_err is tied to 0, and every write applies byte_en as given.

## Structure
- Package dmem_pkg holds:
  - the state enum (IDLE, WAIT, RESP);
  - MEM_READ=1'b1 and MEM_WRITE=1'b0;
  - the wait_cnt width (4 bits);
  - the legal-pattern function used by the misalign check.
- Sub-module dmem_ram is the byte-lane-writable synchronous word array with registered read: ports we, be[3:0], idx, wdata and rdata.
- dmem_responder holds the FSM, the capture registers, the counter and the error logic.

## Test plan
- **Reset:** assert i_rst with WAIT_CYCLES=0 → mem_ready=0, mem_read_data=0, mem_err=0, state IDLE.
- **Write then read:** write 0xDEADBEEF to addr 0x10 with be=1111, then read 0x10 → mem_ready one cycle after each request; mem_read_data=0xDEADBEEF.
- **Byte write:** write data 0x0000AB00, be=0010 to 0x10 over 0xDEADBEEF, then read → 0xDEADABEF.
- **Wait states and aliasing:** WAIT_CYCLES=3, read 0x10 + DEPTH_WORDS*4 → mem_ready exactly 4 cycles after capture; data equals word 4.
- **Reset mid-WAIT:** WAIT_CYCLES=3, write 0x12345678 to 0x20, assert i_rst during WAIT, then read 0x20 → old contents are returned and no mem_ready pulse occurs during reset.
- **Misalign check (DMEM_MISALIGN_CHECK_EN):** write be=0011 at addr 0x21 → mem_err=1 with mem_ready and the word is unchanged. The same write at 0x22 with be=1100 → mem_err=0 and the word is written.
